pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Parametrised successor to the processor's 2:1 next-PC select. Holds the architectural PC register and selects the next PC from NSRC sources.
- Source 0 is the internal sequential PC+STEP. Sources 1..NSRC-1 are external targets (ALU/branch, jump, trap vector, ...).
- Adds stall, a one-entry buffered high-priority redirect with valid/ready handshake, alignment checking, and a count of non-sequential transfers.
- Sits between the ALU/branch adder outputs and instruction memory address.

Parameters:
- WIDTH, 32, PC and target width in bits.
- NSRC, 4, number of next-PC sources including the internal sequential source 0; must be >= 2.
- SELW, $clog2(NSRC), width of the source select.
- STEP, 4, sequential increment.
- ALIGN_BITS, 2, low PC bits that must be zero.
- RESET_PC, 0, PC value after reset.
- CNTW, 16, width of the non-sequential transfer counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall, PC holds.
- src_sel  in  SELW  source select; 0 = PC+STEP.
- src_data  in  NSRC*WIDTH  flattened targets; slice k = bits [k*WIDTH +: WIDTH]; slice 0 is ignored.
- redir_valid  in  1  redirect request (trap/flush).
- redir_pc  in  WIDTH  redirect target.
- redir_ready  out  1  redirect buffer can accept.
- pc_out  out  WIDTH  current PC (registered).
- pc_seq  out  WIDTH  pc_out+STEP, combinational.
- misalign_err  out  1  one-cycle pulse: rejected misaligned target.
- nonseq_cnt  out  CNTW  count of accepted non-sequential updates.

Behaviour:
- Reset (synchronous, active-high; has priority over all other inputs):
  - pc_out=RESET_PC, misalign_err=0, nonseq_cnt=0.
  - Redirect buffer is emptied, state=RUN, redir_ready=1.
  - A redirect accepted in the same cycle as reset is dropped.
- States:
  - RUN: buffer empty; redir_ready=1.
  - HOLD: buffer holds one redirect; redir_ready=0.
- Redirect handshake:
  - Transfer occurs when redir_valid && redir_ready.
  - In RUN with en=1, an accepted redirect is applied directly this edge and the state stays RUN.
  - In RUN with en=0, the redirect is captured into the buffer and the state goes to HOLD.
  - In HOLD with en=1, the buffered target is applied and the state returns to RUN. redir_ready rises the following cycle; there is no same-cycle refill.
  - In HOLD with en=0, everything holds and new redirects are back-pressured.
- Target selection when en=1, in priority order:
  1. Buffered redirect (HOLD).
  2. Accepted incoming redirect.
  3. src_sel.
  - src_sel=0 -> pc_seq.
  - src_sel in 1..NSRC-1 -> src_data slice.
  - src_sel >= NSRC (only possible when NSRC is not a power of 2) -> treated as 0.
- Alignment:
  - If the chosen target has any of the low ALIGN_BITS bits set, pc_out holds and misalign_err=1 for exactly the next cycle.
  - A rejected redirect is still consumed: the buffer empties and the state returns to RUN.
  - Sequential targets are always aligned, given an aligned RESET_PC and STEP.
- Counter:
  - nonseq_cnt increments on every accepted update whose source is not sequential, including redirects.
  - Misaligned-rejected and stalled cycles do not count.
  - Wraps modulo 2^CNTW.
- Arithmetic:
  - pc_seq wraps modulo 2^WIDTH; all-ones aligned PC + STEP wraps to a low value with no error.
- Latency:
  - pc_out reflects the selected target one clock after the enabled edge.
  - misalign_err is registered, so it is seen one cycle after the offending edge.
  - pc_seq is combinational from pc_out.

Decomposition:
- Shared package holds:
  - Source index constants: SRC_SEQ=0, SRC_BRANCH=1, SRC_JUMP=2, SRC_TRAP=3.
  - State encoding RUN/HOLD.
  - Default WIDTH/STEP/ALIGN_BITS.
- Natural sub-module: pc_src_mux, a parametrised NSRC:1 combinational mux with out-of-range -> index 0. It is reusable for other datapath muxes.

Test Plan:
1. Reset then en=1, src_sel=0 for 3 cycles -> pc_out 0x0, 0x4, 0x8, 0xC; nonseq_cnt=0.
2. pc_out=0x10, src_sel=1, src_data[1]=0x100 -> pc_out=0x100 next cycle, nonseq_cnt=1. Then en=0 for 2 cycles -> pc_out stays 0x100 and the count stays 1.
3. en=0, redir_valid=1, redir_pc=0x200 -> redir_ready=0 next cycle, pc unchanged. A second redirect 0x300 is held off. Then en=1, src_sel=1 -> pc_out=0x200, redir_ready=1 one cycle later, and 0x300 is accepted afterwards.
4. en=1, redir_valid=1 (0x400) with src_sel=1 (0x500) in the same cycle -> pc_out=0x400.
5. src_sel=2, src_data[2]=0x102 -> pc_out holds, misalign_err pulses for 1 cycle, nonseq_cnt unchanged.
6. Reset asserted while in HOLD with 0x600 buffered -> pc_out=RESET_PC, redir_ready=1, 0x600 never appears; pc_out=0xFFFFFFFC with src_sel=0 -> 0x0.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// Shared constants and types for the next-PC unit.
package pc_next_unit_pkg;

    // Source index assignments on the next-PC mux
    localparam int unsigned SRC_SEQ    = 0;
    localparam int unsigned SRC_BRANCH = 1;
    localparam int unsigned SRC_JUMP   = 2;
    localparam int unsigned SRC_TRAP   = 3;

    // Default datapath geometry
    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_STEP       = 4;
    localparam int unsigned DEF_ALIGN_BITS = 2;

    // Redirect buffer state: StRun = empty, StHold = one redirect buffered
    typedef enum logic {
        StRun  = 1'b0,
        StHold = 1'b1
    } redir_state_e;

endpackage

// File: rtl/pc_next_unit_src_mux.sv
// Parametrised NSRC:1 combinational mux; out-of-range selects fall back to index 0.
module pc_src_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned SELW  = $clog2(NSRC)
) (
    input  logic [SELW-1:0]       sel_i,
    input  logic [NSRC*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  alt_o    // a non-zero, in-range input was selected
);

    // Default to slice 0, override on an exact match with any other index
    always_comb begin
        data_o = data_i[0 +: WIDTH];
        alt_o  = 1'b0;
        for (int unsigned k = 1; k < NSRC; k++) begin
            if (sel_i == SELW'(k)) begin
                data_o = data_i[k*WIDTH +: WIDTH];
                alt_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register with NSRC-way next-PC select, stall, one-entry
// buffered redirect, alignment check and non-sequential transfer counter.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int unsigned     WIDTH      = DEF_WIDTH,
    parameter int unsigned     NSRC       = 4,
    parameter int unsigned     SELW       = $clog2(NSRC),
    parameter int unsigned     STEP       = DEF_STEP,
    parameter int unsigned     ALIGN_BITS = DEF_ALIGN_BITS,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned     CNTW       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [SELW-1:0]       src_sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  redir_valid,
    input  logic [WIDTH-1:0]      redir_pc,
    output logic                  redir_ready,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      pc_seq,
    output logic                  misalign_err,
    output logic [CNTW-1:0]       nonseq_cnt
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    redir_state_e     state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [NSRC*WIDTH-1:0] mux_in;
    logic [WIDTH-1:0]      mux_out;
    logic                  mux_alt;
    logic                  redir_acc;
    logic [WIDTH-1:0]      target;
    logic                  target_nonseq;
    logic                  unused_src0;

    assign pc_seq       = pc_q + WIDTH'(STEP);
    assign pc_out       = pc_q;
    assign misalign_err = err_q;
    assign nonseq_cnt   = cnt_q;
    assign redir_ready  = (state_q == StRun);
    assign redir_acc    = redir_valid && redir_ready;

    // Slice 0 of src_data is replaced by the internal sequential PC
    assign mux_in      = {src_data[NSRC*WIDTH-1:WIDTH], pc_seq};
    assign unused_src0 = ^src_data[WIDTH-1:0];

    pc_src_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SELW  (SELW)
    ) u_src_mux (
        .sel_i  (src_sel),
        .data_i (mux_in),
        .data_o (mux_out),
        .alt_o  (mux_alt)
    );

    // Pick the target by priority: buffered redirect, incoming redirect, src_sel
    always_comb begin
        target        = mux_out;
        target_nonseq = mux_alt;
        if (state_q == StHold) begin
            target        = buf_q;
            target_nonseq = 1'b1;
        end else if (redir_acc) begin
            target        = redir_pc;
            target_nonseq = 1'b1;
        end
    end

    // Next-state: PC update, redirect buffering, error pulse and counter
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pc_d    = pc_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (en) begin
            // A buffered redirect is consumed even if it turns out misaligned
            state_d = StRun;
            if ((target & ALIGN_MASK) != '0) begin
                err_d = 1'b1;
            end else begin
                pc_d = target;
                if (target_nonseq) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
        end else if (redir_acc) begin
            buf_d   = redir_pc;
            state_d = StHold;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            buf_q   <= '0;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus randomized
// traffic against a behavioural reference model.
module tb_pc_next_unit;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic           en;
    logic [1:0]     src_sel;
    logic [N*W-1:0] src_data;
    logic           redir_valid;
    logic [W-1:0]   redir_pc;
    logic           redir_ready;
    logic [W-1:0]   pc_out;
    logic [W-1:0]   pc_seq;
    logic           misalign_err;
    logic [15:0]    nonseq_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0] m_pc;
    logic [W-1:0] m_q[$];
    logic         m_err;
    logic [15:0]  m_cnt;

    pc_next_unit dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .src_sel      (src_sel),
        .src_data     (src_data),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .redir_ready  (redir_ready),
        .pc_out       (pc_out),
        .pc_seq       (pc_seq),
        .misalign_err (misalign_err),
        .nonseq_cnt   (nonseq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one edge using the inputs currently applied
    task automatic model_step();
        logic [W-1:0] t;
        bit           ns;
        bit           can_take;
        if (reset) begin
            m_pc  = 32'h0;
            m_q.delete();
            m_err = 1'b0;
            m_cnt = 16'd0;
        end else begin
            can_take = (m_q.size() == 0);
            m_err    = 1'b0;
            if (en) begin
                if (m_q.size() != 0) begin
                    t  = m_q.pop_front();
                    ns = 1;
                end else if (redir_valid && can_take) begin
                    t  = redir_pc;
                    ns = 1;
                end else if (src_sel != 0) begin
                    t  = src_data[int'(src_sel)*W +: W];
                    ns = 1;
                end else begin
                    t  = m_pc + 32'd4;
                    ns = 0;
                end
                if (t % 4 != 0) m_err = 1'b1;
                else begin
                    m_pc = t;
                    if (ns) m_cnt = m_cnt + 16'd1;
                end
            end else if (redir_valid && can_take) begin
                m_q.push_back(redir_pc);
            end
        end
    endtask

    // One clock: update the model, take the edge, settle 1 time unit after it
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; en = 0; src_sel = 0; src_data = '0; redir_valid = 0; redir_pc = '0;
        tick();
        tick();
        n_tests++;
        if (pc_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0);
        end
        n_tests++;
        if (redir_ready !== 1'b1 || misalign_err !== 1'b0 || nonseq_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b err=%b cnt=%0d want 1 0 0",
                     redir_ready, misalign_err, nonseq_cnt);
        end
    endtask

    task automatic test_sequential();
        reset = 0; en = 1; src_sel = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (pc_out !== 32'(4 * i) || pc_out !== m_pc) begin
                n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_out, 32'(4 * i));
            end
        end
        n_tests++;
        if (pc_seq !== 32'h14 || nonseq_cnt !== 16'd0) begin
            n_fail++; $display("FAIL seq_cnt: pc_seq=%h cnt=%0d want 14 0", pc_seq, nonseq_cnt);
        end
    endtask

    task automatic test_branch_stall();
        src_sel = 1; src_data[1*W +: W] = 32'h100;
        tick();
        n_tests++;
        if (pc_out !== 32'h100 || nonseq_cnt !== 16'd1) begin
            n_fail++; $display("FAIL branch: pc=%h cnt=%0d want 100 1", pc_out, nonseq_cnt);
        end
        en = 0;
        tick();
        tick();
        n_tests++;
        if (pc_out !== 32'h100 || nonseq_cnt !== 16'd1) begin
            n_fail++; $display("FAIL stall: pc=%h cnt=%0d want 100 1", pc_out, nonseq_cnt);
        end
    endtask

    task automatic test_redirect_hold();
        en = 0; redir_valid = 1; redir_pc = 32'h200;
        tick();
        n_tests++;
        if (redir_ready !== 1'b0 || pc_out !== 32'h100) begin
            n_fail++; $display("FAIL hold_enter: ready=%b pc=%h want 0 100", redir_ready, pc_out);
        end
        redir_pc = 32'h300;
        tick();
        n_tests++;
        if (redir_ready !== 1'b0 || pc_out !== 32'h100) begin
            n_fail++; $display("FAIL hold_backpress: ready=%b pc=%h want 0 100", redir_ready, pc_out);
        end
        en = 1; src_sel = 1;
        tick();
        n_tests++;
        if (pc_out !== 32'h200 || redir_ready !== 1'b1 || nonseq_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL hold_apply: pc=%h ready=%b cnt=%0d want 200 1 2",
                     pc_out, redir_ready, nonseq_cnt);
        end
        tick();
        n_tests++;
        if (pc_out !== 32'h300 || nonseq_cnt !== 16'd3) begin
            n_fail++; $display("FAIL hold_refill: pc=%h cnt=%0d want 300 3", pc_out, nonseq_cnt);
        end
        redir_valid = 0;
    endtask

    task automatic test_priority();
        en = 1; redir_valid = 1; redir_pc = 32'h400; src_sel = 1; src_data[1*W +: W] = 32'h500;
        tick();
        redir_valid = 0;
        n_tests++;
        if (pc_out !== 32'h400) begin
            n_fail++; $display("FAIL priority: got %h want %h", pc_out, 32'h400);
        end
    endtask

    task automatic test_misalign();
        logic [15:0] cnt0;
        cnt0 = nonseq_cnt;
        en = 1; src_sel = 2; src_data[2*W +: W] = 32'h102;
        tick();
        n_tests++;
        if (pc_out !== 32'h400 || misalign_err !== 1'b1 || nonseq_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL misalign: pc=%h err=%b cnt=%0d want 400 1 4",
                     pc_out, misalign_err, nonseq_cnt);
        end
        en = 0; src_sel = 0;
        tick();
        n_tests++;
        if (misalign_err !== 1'b0 || nonseq_cnt !== cnt0) begin
            n_fail++; $display("FAIL misalign_pulse: err=%b cnt=%0d want 0 %0d",
                               misalign_err, nonseq_cnt, cnt0);
        end
        // Misaligned buffered redirect is consumed without updating the PC
        redir_valid = 1; redir_pc = 32'h7F1;
        tick();
        redir_valid = 0; en = 1;
        tick();
        n_tests++;
        if (pc_out !== 32'h400 || misalign_err !== 1'b1 || redir_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_redir: pc=%h err=%b ready=%b want 400 1 1",
                     pc_out, misalign_err, redir_ready);
        end
    endtask

    task automatic test_reset_in_hold();
        en = 0; redir_valid = 1; redir_pc = 32'h600;
        tick();
        redir_valid = 0; reset = 1;
        tick();
        n_tests++;
        if (pc_out !== 32'h0 || redir_ready !== 1'b1 || nonseq_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_hold: pc=%h ready=%b cnt=%0d want 0 1 0",
                     pc_out, redir_ready, nonseq_cnt);
        end
        // A redirect offered during reset must be dropped
        redir_valid = 1; redir_pc = 32'h700;
        tick();
        redir_valid = 0; reset = 0; en = 1; src_sel = 0;
        tick();
        n_tests++;
        if (pc_out !== 32'h4) begin
            n_fail++; $display("FAIL reset_drop: got %h want %h", pc_out, 32'h4);
        end
    endtask

    task automatic test_wrap();
        en = 1; src_sel = 3; src_data[3*W +: W] = 32'hFFFF_FFFC;
        tick();
        n_tests++;
        if (pc_out !== 32'hFFFF_FFFC || pc_seq !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pre: pc=%h seq=%h want fffffffc 0", pc_out, pc_seq);
        end
        src_sel = 0;
        tick();
        n_tests++;
        if (pc_out !== 32'h0 || misalign_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap: pc=%h err=%b want 0 0", pc_out, misalign_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 99) < 2);
            en          = ($urandom_range(0, 3) != 0);
            src_sel     = 2'($urandom_range(0, 3));
            redir_valid = ($urandom_range(0, 3) == 0);
            redir_pc    = $urandom & ((($urandom_range(0, 7)) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            for (int k = 0; k < N; k++) begin
                src_data[k*W +: W] = $urandom &
                    ((($urandom_range(0, 7)) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            end
            tick();
            n_tests++;
            if (pc_out !== m_pc || pc_seq !== m_pc + 32'd4 || misalign_err !== m_err ||
                nonseq_cnt !== m_cnt || redir_ready !== (m_q.size() == 0)) begin
                n_fail++;
                $display("FAIL rand[%0d]: pc=%h/%h err=%b/%b cnt=%0d/%0d ready=%b/%b (got/want)",
                         i, pc_out, m_pc, misalign_err, m_err, nonseq_cnt, m_cnt,
                         redir_ready, (m_q.size() == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_stall();
        test_redirect_hold();
        test_priority();
        test_misalign();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
